filter_select_declick: RTL and testbench
========================================

// Module: filter_select_declick
// PURPOSE
//   Click-free filter-mode switcher wrapped around the selectable FIR low-pass stage.
//   Owns the filter's filt_sel input and consumes its q output (our d).
//   On a new mode request, ramps output gain to zero, switches filt_sel, waits for the
//   FIR delay line to flush, then ramps gain back up. One sample per clk, same as the FIR.
// PARAMETERS
//   BIT_WIDTH   24  sample width, signed two's complement
//   RAMP_SHIFT  6   ramp length = 2^RAMP_SHIFT samples; FULL = 2^RAMP_SHIFT
//   SETTLE      16  silent samples after a switch, >= FIR depth; legal range 1..255
// PORTS
//   clk       in   1          sample clock, rising edge
//   reset_n   in   1          synchronous, active-low reset
//   sel_req   in   3          requested filter mode, synchronous to clk
//   d         in   BIT_WIDTH  signed sample from FIR q output
//   filt_sel  out  3          registered mode driven to FIR filt_sel
//   q         out  BIT_WIDTH  signed gain-scaled sample, registered
//   busy      out  1          high whenever state != PASS
// BEHAVIOUR
//   Reset, sampled at clk edge with reset_n=0:
//     state=SETTLE, cnt=SETTLE-1, gain=0, filt_sel=3'b000, q=0, busy=1.
//     Reset overrides any operation in progress, including mid-ramp.
//   Datapath:
//     q <= (d * gain) >>> RAMP_SHIFT, with a signed product of BIT_WIDTH+RAMP_SHIFT+1 bits.
//     Latency is 1 clk. Truncation is an arithmetic floor.
//     gain is 0..FULL, so no overflow occurs. At gain=FULL, q equals d exactly,
//     including -2^(BIT_WIDTH-1).
//   State machine (one transition per clk):
//     PASS: gain=FULL. If sel_req != filt_sel, go to RAMP_DOWN.
//     RAMP_DOWN: gain decrements by 1 per clk.
//       If sel_req == filt_sel, go to RAMP_UP from the current gain (abort; filt_sel unchanged).
//       Otherwise, when gain goes 1->0, go to SWITCH.
//     SWITCH (1 clk): filt_sel <= sel_req, cnt <= SETTLE-1, go to SETTLE. gain stays 0.
//     SETTLE: gain=0, cnt decrements.
//       If sel_req != filt_sel, go to SWITCH (settle restarts).
//       Otherwise, when cnt==0, go to RAMP_UP.
//     RAMP_UP: gain increments by 1 per clk.
//       If sel_req != filt_sel, go to RAMP_DOWN from the current gain.
//       When gain goes FULL-1 -> FULL, go to PASS.
//   Timing for an uninterrupted switch, with mismatch first sampled at edge E:
//     - filt_sel changes at edge E+FULL+1.
//     - busy is high from edge E to edge E+2*FULL+SETTLE+1 (145 clks at defaults).
//   sel_req changes while in PASS and RAMP_DOWN never reach filt_sel until gain=0.
//   filt_sel only changes in SWITCH.
//   After reset release: SETTLE clks at gain=0, then FULL-clk ramp up, then PASS.
//   busy is a decode of the registered state, so it has no combinational path from sel_req.
// TESTING
//   1. Reset with sel_req=0, d=24'h100000 constant.
//      -> q=0 for 16 clks after release, then rises by 24'h004000 per clk to 24'h100000.
//      -> busy falls after 16+64 clks.
//   2. In PASS, d steps 24'h7FFFFF -> 24'h800000.
//      -> q follows exactly, 1 clk later; busy=0.
//   3. In PASS, sel_req 0->3.
//      -> q ramps down over 64 clks; filt_sel=3 at edge E+65.
//      -> q=0 through SETTLE; ramps back up; busy high for exactly 145 clks.
//   4. sel_req 0->5, then back to 0 while gain=40.
//      -> gain climbs from 40 to 64; filt_sel stays 0.
//      -> no zero-gain cycle; busy drops after 24 clks.
//   5. sel_req 0->2; during SETTLE (cnt=5) sel_req->6.
//      -> second SWITCH sets filt_sel=6; full 16-clk SETTLE restarts before ramp up.
//   6. reset_n=0 for 1 clk mid RAMP_UP with filt_sel=4.
//      -> next clk: filt_sel=0, q=0, gain=0, busy=1, state SETTLE.

Source files
------------

// File: rtl/filter_select_declick.sv
// filter_select_declick
//   Click-free mode switcher wrapped around the selectable FIR low-pass stage.
//   A new mode request fades the output gain to zero and then moves filt_sel.
//   The block then holds the output silent while the FIR delay line flushes.
//   Finally it fades the gain back up to unity.
//   One sample is processed per clk. q carries one clk of latency relative to d.
module filter_select_declick #(
  parameter int BIT_WIDTH  = 24,
  parameter int RAMP_SHIFT = 6,
  parameter int SETTLE     = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [2:0]                  sel_req,
  input  logic signed [BIT_WIDTH-1:0] d,
  output logic [2:0]                  filt_sel,
  output logic signed [BIT_WIDTH-1:0] q,
  output logic                        busy
);

  // gain spans 0..FULL inclusive, so it needs one bit more than RAMP_SHIFT.
  localparam int GAIN_W = RAMP_SHIFT + 1;
  // The product width is wide enough for d * FULL, including the most negative d.
  localparam int PROD_W = BIT_WIDTH + RAMP_SHIFT + 1;

  localparam logic [GAIN_W-1:0] GAIN_ZERO   = {GAIN_W{1'b0}};
  localparam logic [GAIN_W-1:0] GAIN_ONE    = {{RAMP_SHIFT{1'b0}}, 1'b1};
  localparam logic [GAIN_W-1:0] GAIN_FULL   = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GAIN_W-1:0] GAIN_TOP    = GAIN_FULL - GAIN_ONE;
  localparam logic [7:0]        CNT_ZERO    = 8'd0;
  localparam logic [7:0]        CNT_ONE     = 8'd1;
  localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_PASS      = 3'd0,
    ST_RAMP_DOWN = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RAMP_UP   = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [GAIN_W-1:0]           gain_q, gain_d;
  logic [2:0]                  filt_sel_q, filt_sel_d;
  logic signed [BIT_WIDTH-1:0] q_q, q_d;
  logic                        busy_q, busy_d;

  logic                        sel_match_s;
  logic signed [PROD_W-1:0]    d_ext_s;
  logic signed [PROD_W-1:0]    gain_ext_s;
  logic signed [PROD_W-1:0]    prod_s;

  // Compare the request against the mode the FIR is currently running.
  always_comb begin
    sel_match_s = (sel_req == filt_sel_q);
  end

  // Next-state, gain-ramp, settle-count and mode selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gain_d     = gain_q;
    filt_sel_d = filt_sel_q;
    case (state_q)
      ST_PASS: begin
        gain_d = GAIN_FULL;
        if (!sel_match_s) begin
          state_d = ST_RAMP_DOWN;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_RAMP_DOWN: begin
        if (sel_match_s) begin
          // Request withdrawn: climb back from wherever the fade got to.
          state_d = ST_RAMP_UP;
        end else if (gain_q <= GAIN_ONE) begin
          // Last step of the fade; also covers entry at gain 0 from RAMP_UP.
          gain_d  = GAIN_ZERO;
          state_d = ST_SWITCH;
        end else begin
          gain_d  = gain_q - GAIN_ONE;
          state_d = ST_RAMP_DOWN;
        end
      end
      ST_SWITCH: begin
        gain_d     = GAIN_ZERO;
        filt_sel_d = sel_req;
        cnt_d      = SETTLE_LOAD;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        gain_d = GAIN_ZERO;
        if (!sel_match_s) begin
          // A new request during the flush restarts the whole settle period.
          state_d = ST_SWITCH;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_RAMP_UP;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_SETTLE;
        end
      end
      ST_RAMP_UP: begin
        if (!sel_match_s) begin
          state_d = ST_RAMP_DOWN;
        end else if (gain_q >= GAIN_TOP) begin
          // Saturate at FULL, even when entering at FULL after an early abort.
          gain_d  = GAIN_FULL;
          state_d = ST_PASS;
        end else begin
          gain_d  = gain_q + GAIN_ONE;
          state_d = ST_RAMP_UP;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        gain_d  = GAIN_ZERO;
        cnt_d   = SETTLE_LOAD;
      end
    endcase
  end

  // Scale the incoming sample by the gain that applies in the next cycle.
  // Arithmetic shift floors the result. At FULL, q equals d exactly.
  always_comb begin
    d_ext_s    = PROD_W'(d);
    gain_ext_s = PROD_W'(gain_d);
    prod_s     = d_ext_s * gain_ext_s;
    q_d        = BIT_WIDTH'(prod_s >>> RAMP_SHIFT);
    busy_d     = (state_d != ST_PASS);
  end

  // State, counters and registered outputs, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_SETTLE;
      cnt_q      <= SETTLE_LOAD;
      gain_q     <= GAIN_ZERO;
      filt_sel_q <= 3'b000;
      q_q        <= {BIT_WIDTH{1'b0}};
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gain_q     <= gain_d;
      filt_sel_q <= filt_sel_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
    end
  end

  assign filt_sel = filt_sel_q;
  assign q        = q_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_filter_select_declick.sv
// Directed testbench for filter_select_declick at default parameters.
module tb_filter_select_declick;

  logic        clk;
  logic        reset_n;
  logic [2:0]  sel_req;
  logic [23:0] d;
  logic [2:0]  filt_sel;
  logic [23:0] q;
  logic        busy;

  int checks;
  int failures;

  filter_select_declick #(
    .BIT_WIDTH (24),
    .RAMP_SHIFT(6),
    .SETTLE    (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sel_req (sel_req),
    .d       (d),
    .filt_sel(filt_sel),
    .q       (q),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scaling: floor(dval * g / 64), computed by integer floor division.
  function automatic logic [23:0] exp_q(input int dval, input int g);
    int x;
    int r;
    x = dval * g;
    if (x >= 0) r = x / 64;
    else        r = -((-x + 63) / 64);
    return r[23:0];
  endfunction

  task automatic test_reset();
    d       = 24'h100000;
    sel_req = 3'd0;
    reset_n = 1'b0;
    tick();
    checks++; if (q !== 24'h000000) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 24'h000000); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL reset_filt_sel got=%0d exp=0", filt_sel); end
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (q !== 24'h000000) begin failures++; $display("FAIL reset_settle_q k=%0d got=%h exp=000000", k, q); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_settle_busy k=%0d got=%b exp=1", k, busy); end
    end
    for (int k = 1; k <= 64; k++) begin
      logic [23:0] e;
      e = 24'(k * 32'h4000);
      tick();
      checks++; if (q !== e) begin failures++; $display("FAIL reset_rampup_q k=%0d got=%h exp=%h", k, q, e); end
      checks++; if (busy !== (k != 64)) begin failures++; $display("FAIL reset_rampup_busy k=%0d got=%b exp=%b", k, busy, (k != 64)); end
    end
  endtask

  task automatic test_passthrough();
    d = 24'h7FFFFF;
    tick();
    checks++; if (q !== 24'h7FFFFF) begin failures++; $display("FAIL pass_max got=%h exp=7fffff", q); end
    d = 24'h800000;
    tick();
    checks++; if (q !== 24'h800000) begin failures++; $display("FAIL pass_min got=%h exp=800000", q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pass_busy got=%b exp=0", busy); end
    d = 24'hFFFF9C;
    tick();
    checks++; if (q !== 24'hFFFF9C) begin failures++; $display("FAIL pass_neg got=%h exp=ffff9c", q); end
  endtask

  // 0 -> 5, back to 0 once gain reaches 40; d = -100 exercises floor rounding.
  task automatic test_abort();
    int g;
    sel_req = 3'd5;
    d       = 24'hFFFF9C;
    for (int j = 0; j <= 49; j++) begin
      g = (j <= 24) ? (64 - j) : (40 + (j - 25));
      tick();
      checks++; if (q !== exp_q(-100, g)) begin failures++; $display("FAIL abort_q j=%0d got=%h exp=%h", j, q, exp_q(-100, g)); end
      checks++; if (busy !== (j < 49)) begin failures++; $display("FAIL abort_busy j=%0d got=%b exp=%b", j, busy, (j < 49)); end
      checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL abort_filt_sel j=%0d got=%0d exp=0", j, filt_sel); end
      if (j == 24) sel_req = 3'd0;
    end
  endtask

  // Uninterrupted 0 -> 3 switch; busy for exactly 145 clks.
  task automatic test_switch();
    int g;
    sel_req = 3'd3;
    d       = 24'h100000;
    for (int j = 0; j <= 146; j++) begin
      if (j == 0)       g = 64;
      else if (j <= 64) g = 64 - j;
      else if (j <= 81) g = 0;
      else if (j <= 145) g = j - 81;
      else              g = 64;
      tick();
      checks++; if (q !== exp_q(32'h100000, g)) begin failures++; $display("FAIL switch_q j=%0d got=%h exp=%h", j, q, exp_q(32'h100000, g)); end
      checks++; if (busy !== (j < 145)) begin failures++; $display("FAIL switch_busy j=%0d got=%b exp=%b", j, busy, (j < 145)); end
      checks++; if (filt_sel !== ((j >= 65) ? 3'd3 : 3'd0)) begin failures++; $display("FAIL switch_filt_sel j=%0d got=%0d exp=%0d", j, filt_sel, ((j >= 65) ? 3'd3 : 3'd0)); end
    end
  endtask

  // 3 -> 2, then 6 requested while the settle counter reads 5.
  task automatic test_settle_restart();
    int g;
    logic [2:0] ef;
    sel_req = 3'd2;
    for (int j = 0; j <= 157; j++) begin
      if (j == 0)        g = 64;
      else if (j <= 64)  g = 64 - j;
      else if (j <= 93)  g = 0;
      else               g = j - 93;
      if (j < 65)        ef = 3'd3;
      else if (j < 77)   ef = 3'd2;
      else               ef = 3'd6;
      tick();
      checks++; if (q !== exp_q(32'h100000, g)) begin failures++; $display("FAIL restart_q j=%0d got=%h exp=%h", j, q, exp_q(32'h100000, g)); end
      checks++; if (busy !== (j < 157)) begin failures++; $display("FAIL restart_busy j=%0d got=%b exp=%b", j, busy, (j < 157)); end
      checks++; if (filt_sel !== ef) begin failures++; $display("FAIL restart_filt_sel j=%0d got=%0d exp=%0d", j, filt_sel, ef); end
      if (j == 75) sel_req = 3'd6;
    end
  endtask

  // Switch 6 -> 4, then reset for one clk partway up the ramp.
  task automatic test_reset_mid_ramp();
    sel_req = 3'd4;
    for (int j = 0; j <= 100; j++) begin
      tick();
    end
    checks++; if (filt_sel !== 3'd4) begin failures++; $display("FAIL midramp_filt_sel got=%0d exp=4", filt_sel); end
    checks++; if (q !== 24'h04C000) begin failures++; $display("FAIL midramp_q got=%h exp=04c000", q); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midramp_busy got=%b exp=1", busy); end
    reset_n = 1'b0;
    sel_req = 3'd0;
    tick();
    reset_n = 1'b1;
    checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL midrst_filt_sel got=%0d exp=0", filt_sel); end
    checks++; if (q !== 24'h000000) begin failures++; $display("FAIL midrst_q got=%h exp=000000", q); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (q !== ((k == 17) ? 24'h004000 : 24'h000000)) begin failures++; $display("FAIL midrst_settle_q k=%0d got=%h exp=%h", k, q, ((k == 17) ? 24'h004000 : 24'h000000)); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_settle_busy k=%0d got=%b exp=1", k, busy); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    sel_req  = 3'd0;
    d        = 24'h000000;
    test_reset();
    test_passthrough();
    test_abort();
    test_switch();
    test_settle_restart();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
